// File: rtl/alu_div_seq.sv
// RV32M divide sequencer: restoring division, one quotient bit per two
// cycles, borrowing the execute-stage ALU instead of owning a divider.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SGEU = 4'd3
  } alu_op_t;
endpackage

module alu_div_seq
  import alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  input  logic            flush,
  output logic            alu_own,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  input  logic [XLEN-1:0] alu_result
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("alu_div_seq supports XLEN=32 only");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_CMP, S_SUB, S_FIX, S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t          state_q;
  logic [1:0]      op_q;
  logic            sa_q, sb_q, bz_q, ge_q;
  logic [XLEN-1:0] dvd_q, dvs_q, rem_q;
  logic [4:0]      cnt_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;

  logic [XLEN-1:0] rs;
  logic [XLEN-1:0] fix_x;
  logic            fix_neg;
  logic            req_sgn, req_bz, req_special;
  logic [XLEN-1:0] fast_data_d;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign alu_own    = (state_q != S_IDLE) && (state_q != S_DONE);

  // Remainder shifted left with the next dividend bit.
  assign rs = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};

  always_comb begin
    req_sgn     = ~req_op[0];
    req_bz      = (req_b == '0);
    req_special = req_bz ||
                  (req_sgn && req_a == MIN_NEG && req_b == ALL_ONES);
    fast_data_d = '0;
    if (req_op[1]) begin
      fast_data_d = req_bz ? req_a : '0;
    end else begin
      fast_data_d = req_bz ? ALL_ONES : MIN_NEG;
    end
  end

  // Division by zero keeps the all-ones quotient regardless of signs.
  always_comb begin
    fix_x   = op_q[1] ? rem_q : dvd_q;
    fix_neg = op_q[1] ? sa_q : ((sa_q ^ sb_q) & ~bz_q);
  end

  always_comb begin
    alu_op   = ALU_NOP;
    alu_src1 = '0;
    alu_src2 = '0;
    unique case (state_q)
      S_NEG_A: begin
        if (sa_q) begin
          alu_op   = ALU_SUB;
          alu_src2 = dvd_q;
        end else begin
          alu_src1 = dvd_q;
        end
      end
      S_NEG_B: begin
        if (sb_q) begin
          alu_op   = ALU_SUB;
          alu_src2 = dvs_q;
        end else begin
          alu_src1 = dvs_q;
        end
      end
      S_CMP: begin
        alu_op   = ALU_SGEU;
        alu_src1 = rs;
        alu_src2 = dvs_q;
      end
      S_SUB: begin
        alu_op   = ALU_SUB;
        alu_src1 = rs;
        alu_src2 = dvs_q;
      end
      S_FIX: begin
        if (fix_neg) begin
          alu_op   = ALU_SUB;
          alu_src2 = fix_x;
        end else begin
          alu_src1 = fix_x;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      bz_q         <= 1'b0;
      ge_q         <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            sa_q  <= req_sgn & req_a[XLEN-1];
            sb_q  <= req_sgn & req_b[XLEN-1];
            bz_q  <= req_bz;
            dvd_q <= req_a;
            dvs_q <= req_b;
            if (FAST_SPECIAL && req_special) begin
              resp_data_q  <= fast_data_d;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_NEG_A;
            end
          end
        end
        S_NEG_A: begin
          dvd_q   <= alu_result;
          state_q <= S_NEG_B;
        end
        S_NEG_B: begin
          dvs_q   <= alu_result;
          rem_q   <= '0;
          cnt_q   <= 5'd31;
          state_q <= S_CMP;
        end
        S_CMP: begin
          // A set top bit means the 33-bit partial remainder beats any divisor.
          ge_q    <= rem_q[XLEN-1] | alu_result[0];
          state_q <= S_SUB;
        end
        S_SUB: begin
          rem_q   <= ge_q ? alu_result : rs;
          dvd_q   <= {dvd_q[XLEN-2:0], ge_q};
          cnt_q   <= cnt_q - 5'd1;
          state_q <= (cnt_q == 5'd0) ? S_FIX : S_CMP;
        end
        S_FIX: begin
          resp_data_q  <= alu_result;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Randomized and directed checks of alu_div_seq against an arithmetic
// reference, with instance 0 on the fast special path and 1 fully iterative.
module tb_alu_div_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data [2];
  logic        flush [2];
  logic        alu_own [2];
  alu_op_t     alu_op [2];
  logic [31:0] alu_src1 [2];
  logic [31:0] alu_src2 [2];
  logic [31:0] alu_result [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(alu_op_t op, logic [31:0] x,
                                        logic [31:0] y);
    case (op)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x - y;
      ALU_SGEU: return (x >= y) ? 32'd1 : 32'd0;
      default:  return x;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_div_seq #(.XLEN(32), .FAST_SPECIAL(g == 0)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .flush      (flush[g]),
      .alu_own    (alu_own[g]),
      .alu_op     (alu_op[g]),
      .alu_src1   (alu_src1[g]),
      .alu_src2   (alu_src2[g]),
      .alu_result (alu_result[g])
    );
    assign alu_result[g] = alu_f(alu_op[g], alu_src1[g], alu_src2[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(logic [1:0] op, logic [31:0] a,
                                    logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] ref_f(logic [1:0] op, logic [31:0] a,
                                        logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  task automatic chk_reset(input int d);
    chk("rst_ctl", {req_ready[d], resp_valid[d], alu_own[d]}, 3'b100);
    chk("rst_data", resp_data[d], 0);
    chk("rst_alu", {alu_op[d], alu_src1[d], alu_src2[d]}, 0);
  endtask

  task automatic run_op(input int d, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp;
    int lat, own, exp_lat;
    exp = ref_f(op, a, b);
    exp_lat = (d == 0 && is_special(op, a, b)) ? 1 : 68;
    @(negedge clk);
    chk("req_ready", req_ready[d], 1);
    req_valid[d] = 1'b1;
    req_op[d] = op;
    req_a[d] = a;
    req_b[d] = b;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_a[d] = $urandom;
    req_b[d] = $urandom;
    lat = 1;
    own = 0;
    forever begin
      @(negedge clk);
      if (resp_valid[d] || lat >= 200) break;
      own += int'(alu_own[d]);
      @(posedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("own_cycles", own, (exp_lat == 1) ? 0 : 67);
    chk("resp_data", resp_data[d], exp);
    chk("done_alu", {alu_own[d], alu_op[d], alu_src1[d], alu_src2[d]}, 0);
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      req_op[d] = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold", {resp_valid[d], req_ready[d], resp_data[d]}, {2'b10, exp});
    end
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    chk("release", {resp_valid[d], req_ready[d]}, 2'b01);
  endtask

  task automatic flush_test(input int d);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_op[d] = 2'd1;
    req_a[d] = $urandom;
    req_b[d] = $urandom | 32'h1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush[d] = 1'b1;
    @(posedge clk);
    #1;
    flush[d] = 1'b0;
    @(negedge clk);
    chk("flush_idle", {req_ready[d], resp_valid[d], alu_own[d]}, 3'b100);
    run_op(d, 2'd1, 32'd9, 32'd3, 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[$] = '{
    '{2'd1, 32'd100, 32'd7},
    '{2'd3, 32'd100, 32'd7},
    '{2'd0, 32'hFFFF_FFF9, 32'd2},
    '{2'd2, 32'hFFFF_FFF9, 32'd2},
    '{2'd2, 32'd7, 32'hFFFF_FFFE},
    '{2'd1, 32'hFFFF_FFFF, 32'd1},
    '{2'd3, 32'hFFFF_FFFF, 32'h8000_0001},
    '{2'd0, 32'd5, 32'd0},
    '{2'd2, 32'd5, 32'd0},
    '{2'd0, 32'hFFFF_FFFB, 32'd0},
    '{2'd2, 32'hFFFF_FFFB, 32'd0},
    '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF},
    '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF},
    '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF}
  };

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_op[d] = '0;
      req_a[d] = '0;
      req_b[d] = '0;
      resp_ready[d] = 1'b0;
      flush[d] = 1'b0;
    end
    #12;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      foreach (dir[i]) run_op(d, dir[i].op, dir[i].a, dir[i].b, i % 3);
    run_op(0, 2'd1, 32'd1000, 32'd9, 10);
    run_op(1, 2'd1, 32'd1000, 32'd9, 10);

    for (int n = 0; n < 60; n++)
      run_op(n % 2, 2'($urandom), pick(), pick(), $urandom_range(0, 3));

    flush_test(0);
    flush_test(1);

    // Flush beats an accept in the same cycle; b=0 would finish at once.
    @(negedge clk);
    flush[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_op[0] = 2'd0;
    req_b[0] = 32'd0;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("flush_prio", {req_ready[0], resp_valid[0], alu_own[0]}, 3'b100);

    @(negedge clk);
    req_valid[1] = 1'b1;
    req_op[1] = 2'd0;
    req_a[1] = $urandom;
    req_b[1] = 32'd13;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 2'd3, 32'd100, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
